// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks an execute-side source or waits for load data,
// with a load timeout. Optional macro WB_ZERO_GUARD_EN suppresses writes to register 0.
module wb_select_stage #(
  parameter int DATA_W      = 32,
  parameter int NSRC        = 4,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       src_sel,
  input  logic                   is_load,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_we,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   mem_valid,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   fwd_valid,
  output logic                   load_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  // Handshake: an op transfers on a cycle where in_valid & in_ready; upstream holds it otherwise.
  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  state_t              state_q, state_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                load_err_q, load_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic                ld_we_q, ld_we_d;
  logic [DATA_W-1:0]   sel_data;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    load_err_d = load_err_q;
    cnt_d      = cnt_q;
    ld_addr_d  = ld_addr_q;
    ld_we_d    = ld_we_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_load) begin
            ld_addr_d = rd_addr;
            ld_we_d   = rd_we;
            cnt_d     = '0;
            state_d   = WAIT_MEM;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = rd_we;
            wb_addr_d  = rd_addr;
            wb_data_d  = sel_data;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = ld_we_q;
          wb_addr_d  = ld_addr_q;
          wb_data_d  = mem_data;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: emit a non-writing slot so the pipeline sees the op retire.
          load_err_d = 1'b1;
          wb_valid_d = 1'b1;
          wb_addr_d  = ld_addr_q;
          wb_data_d  = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef WB_ZERO_GUARD_EN
    if (wb_valid_d && (wb_addr_d == '0)) wb_we_d = 1'b0;
`else
    wb_we_d = wb_we_d & wb_valid_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      load_err_q <= 1'b0;
      cnt_q      <= '0;
      ld_addr_q  <= '0;
      ld_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      load_err_q <= load_err_d;
      cnt_q      <= cnt_d;
      ld_addr_q  <= ld_addr_d;
      ld_we_q    <= ld_we_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign fwd_valid = wb_valid_q & wb_we_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios plus randomized traffic against a
// transaction-level model of pending loads and writeback slots.
module tb_wb_select_stage;

  localparam int DATA_W      = 32;
  localparam int NSRC        = 3;
  localparam int SEL_W       = 2;
  localparam int ADDR_W      = 5;
  localparam int MEM_TIMEOUT = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]       src_sel = '0;
  logic                   is_load = 1'b0;
  logic [ADDR_W-1:0]      rd_addr = '0;
  logic                   rd_we = 1'b0;
  logic [DATA_W-1:0]      mem_data = '0;
  logic                   mem_valid = 1'b0;
  logic                   wb_valid, wb_we, fwd_valid, load_err;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic [DATA_W-1:0]      src [NSRC];

  int checks = 0;
  int failures = 0;

  // model state
  logic              m_busy = 1'b0;
  logic              m_err = 1'b0;
  int                m_waited = 0;
  logic [ADDR_W-1:0] m_ld_addr = '0;
  logic              m_ld_we = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;

`ifdef WB_ZERO_GUARD_EN
  localparam logic ZERO_WE = 1'b0;
`else
  localparam logic ZERO_WE = 1'b1;
`endif

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NSRC; k++) src_data[k*DATA_W +: DATA_W] = src[k];
  end

  wb_select_stage #(
    .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .is_load(is_load), .rd_addr(rd_addr),
    .rd_we(rd_we), .mem_data(mem_data), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .fwd_valid(fwd_valid),
    .load_err(load_err)
  );

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic step();
    logic nv;
    nv = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0; m_waited = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        if (is_load) begin
          m_busy = 1'b1; m_ld_addr = rd_addr; m_ld_we = rd_we; m_waited = 0;
        end else begin
          nv = 1'b1; m_we = rd_we; m_addr = rd_addr; m_data = '0;
          if (int'(src_sel) < NSRC) m_data = src[src_sel];
        end
      end
    end else if (mem_valid) begin
      nv = 1'b1; m_we = m_ld_we; m_addr = m_ld_addr; m_data = mem_data; m_busy = 1'b0;
    end else begin
      m_waited++;
      if (m_waited == MEM_TIMEOUT) begin
        nv = 1'b1; m_we = 1'b0; m_addr = m_ld_addr; m_data = '0; m_err = 1'b1; m_busy = 1'b0;
      end
    end
`ifdef WB_ZERO_GUARD_EN
    if (nv && m_addr == '0) m_we = 1'b0;
`endif
    if (!nv) m_we = 1'b0;
    m_valid = nv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; is_load = 1'b0; mem_valid = 1'b0; rd_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", fwd_valid); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_err); end
    checks++; if (wb_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", wb_addr); end
    checks++; if (wb_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_alu();
    src[0] = 32'h0000_1234; src_sel = 2'd0; rd_addr = 5'd5; rd_we = 1'b1; is_load = 1'b0; in_valid = 1'b1;
    step();
    idle_inputs();
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", wb_we); end
    checks++; if (wb_addr !== 5'd5) begin failures++; $display("FAIL alu_addr got=%0d exp=5", wb_addr); end
    checks++; if (wb_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_data got=%h exp=00001234", wb_data); end
    checks++; if (fwd_valid !== 1'b1) begin failures++; $display("FAIL alu_fwd got=%b exp=1", fwd_valid); end
    step();
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL alu_after got=%b%b%b exp=000", wb_valid, wb_we, fwd_valid); end
    checks++; if (wb_data !== 32'h0000_1234 || wb_addr !== 5'd5) begin
      failures++; $display("FAIL alu_hold got=%h/%0d exp=00001234/5", wb_data, wb_addr); end
  endtask

  task automatic test_back_to_back();
    src[1] = 32'hAAAA_0001; src[2] = 32'hBBBB_0002;
    src_sel = 2'd1; rd_addr = 5'd3; rd_we = 1'b1; in_valid = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA_0001 || wb_addr !== 5'd3) begin
      failures++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/aaaa0001/3", wb_valid, wb_data, wb_addr); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    src_sel = 2'd2; rd_addr = 5'd4;
    step();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB_0002 || wb_addr !== 5'd4) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/bbbb0002/4", wb_valid, wb_data, wb_addr); end
    src_sel = 2'd3; rd_addr = 5'd6;
    step();
    idle_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_addr !== 5'd6) begin
      failures++; $display("FAIL sel_oob got=%b/%h/%0d exp=1/00000000/6", wb_valid, wb_data, wb_addr); end
    step();
  endtask

  task automatic test_load();
    is_load = 1'b1; rd_addr = 5'd7; rd_we = 1'b1; in_valid = 1'b1;
    step();
    // held non-load op must not be taken while waiting
    is_load = 1'b0; src_sel = 2'd1; rd_addr = 5'd9;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL load_nopulse got=%b exp=0", wb_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load_ready got=%b exp=0", in_ready); end
    step();
    step();
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL load_wait got=%b/%b exp=0/0", wb_valid, in_ready); end
    in_valid = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_addr !== 5'd7 || wb_we !== 1'b1) begin
      failures++; $display("FAIL load_wb got=%b/%h/%0d/%b exp=1/deadbeef/7/1", wb_valid, wb_data, wb_addr, wb_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL load_ready_back got=%b exp=1", in_ready); end
    // minimum latency: data on the first wait cycle
    is_load = 1'b1; rd_addr = 5'd11; in_valid = 1'b1;
    step();
    idle_inputs(); mem_valid = 1'b1; mem_data = 32'h0BAD_F00D;
    step();
    mem_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_addr !== 5'd11) begin
      failures++; $display("FAIL load_min got=%b/%h/%0d exp=1/0badf00d/11", wb_valid, wb_data, wb_addr); end
    // data arriving on the last allowed wait cycle still completes normally
    is_load = 1'b1; rd_addr = 5'd12; rd_we = 1'b1; in_valid = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    mem_valid = 1'b1; mem_data = 32'h1357_9BDF;
    step();
    mem_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'h1357_9BDF || load_err !== 1'b0) begin
      failures++; $display("FAIL load_edge got=%b/%b/%h/%b exp=1/1/13579bdf/0", wb_valid, wb_we, wb_data, load_err); end
  endtask

  task automatic test_timeout();
    is_load = 1'b1; rd_addr = 5'd13; rd_we = 1'b1; in_valid = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    checks++; if (wb_valid !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL to_early got=%b/%b exp=0/0", wb_valid, load_err); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h0 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL to_pulse got=%b/%b/%h/%b exp=1/0/00000000/0", wb_valid, wb_we, wb_data, fwd_valid); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", load_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", in_ready); end
    step();
    src_sel = 2'd0; rd_addr = 5'd1; rd_we = 1'b1; in_valid = 1'b1;
    step();
    idle_inputs();
    checks++; if (wb_valid !== 1'b1 || load_err !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b/%b exp=1/1", wb_valid, load_err); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", load_err); end
  endtask

  task automatic test_reset_mid_load();
    is_load = 1'b1; rd_addr = 5'd8; rd_we = 1'b1; in_valid = 1'b1;
    step();
    idle_inputs();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_valid = 1'b1; mem_data = 32'hCAFE_0000;
    step();
    mem_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || fwd_valid !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL rst_load_ctl got=%b%b%b%b exp=0000", wb_valid, wb_we, fwd_valid, load_err); end
    checks++; if (wb_data !== '0 || wb_addr !== '0) begin
      failures++; $display("FAIL rst_load_dat got=%h/%0d exp=0/0", wb_data, wb_addr); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_load_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero_guard();
    src[2] = 32'h5555_AAAA; src_sel = 2'd2; rd_addr = 5'd0; rd_we = 1'b1; in_valid = 1'b1;
    step();
    idle_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h5555_AAAA) begin
      failures++; $display("FAIL zero_valid got=%b/%h exp=1/5555aaaa", wb_valid, wb_data); end
    checks++; if (wb_we !== ZERO_WE || fwd_valid !== ZERO_WE) begin
      failures++; $display("FAIL zero_we got=%b/%b exp=%b/%b", wb_we, fwd_valid, ZERO_WE, ZERO_WE); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      is_load   = ($urandom_range(0, 2) == 0);
      src_sel   = SEL_W'($urandom_range(0, 3));
      rd_addr   = ADDR_W'($urandom_range(0, 31));
      rd_we     = ($urandom_range(0, 4) != 0);
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_data  = $urandom;
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      checks++; if (in_ready !== !m_busy) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, !m_busy); end
      step();
      checks++; if (wb_valid !== m_valid || wb_we !== m_we || fwd_valid !== (m_valid & m_we)) begin
        failures++; $display("FAIL rnd_ctl cyc=%0d got=%b%b%b exp=%b%b%b", c, wb_valid, wb_we, fwd_valid,
                             m_valid, m_we, m_valid & m_we); end
      checks++; if (wb_addr !== m_addr || wb_data !== m_data) begin
        failures++; $display("FAIL rnd_dat cyc=%0d got=%0d/%h exp=%0d/%h", c, wb_addr, wb_data, m_addr, m_data); end
      checks++; if (load_err !== m_err) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, load_err, m_err); end
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) src[k] = '0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_timeout();
    test_reset_mid_load();
    test_zero_guard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised, registered writeback-select stage between execute/memory and the register file.
- Selects one of NSRC execute-side sources (ALU, PC+4, immediate, ...) or waits for load data from RAM.
- Presents one registered write to the register file per accepted op, plus a forwarding copy of the same write.
- A load timeout flags a hung memory.

Parameters:
DATA_W, 32, datapath width
NSRC, 4, number of execute-side sources on src_data (min 2)
SEL_W, 2, width of src_sel (must satisfy 2**SEL_W >= NSRC)
ADDR_W, 5, register-file address width
MEM_TIMEOUT, 15, max cycles waiting for mem_valid before abort (min 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  op presented
in_ready  output  1  stage can accept op this cycle
src_data  input  NSRC*DATA_W  flattened sources; source k at bits [k*DATA_W +: DATA_W]
src_sel  input  SEL_W  source index for non-load ops
is_load  input  1  op takes its result from mem_data
rd_addr  input  ADDR_W  destination register
rd_we  input  1  op writes the register file
mem_data  input  DATA_W  RAM read data
mem_valid  input  1  mem_data valid this cycle
wb_valid  output  1  one-cycle pulse: writeback slot occupied
wb_we  output  1  register-file write enable
wb_addr  output  ADDR_W  write address
wb_data  output  DATA_W  write data
fwd_valid  output  1  equals wb_valid & wb_we (forwarding hit qualifier)
load_err  output  1  sticky: a load timed out

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; wb_valid, wb_we, fwd_valid, load_err=0; wb_addr, wb_data=0; timeout counter=0.
- Reset during WAIT_MEM abandons the pending load; no writeback is issued.
- States: IDLE, WAIT_MEM. in_ready=1 in IDLE, 0 in WAIT_MEM (combinational from state).
- IDLE, accept (in_valid & in_ready), is_load=0:
  - Next cycle: wb_valid=1, wb_data=src_data[src_sel], wb_addr=rd_addr, wb_we=rd_we.
  - src_sel >= NSRC selects data 0.
  - Latency 1; back-to-back ops sustain 1 op/cycle.
- IDLE, accept, is_load=1:
  - Latch rd_addr and rd_we; clear counter; go to WAIT_MEM.
  - wb_valid=0 next cycle.
- WAIT_MEM, mem_valid=1:
  - Next cycle: wb_valid=1, wb_data=mem_data, latched addr/we; go to IDLE.
  - Minimum load latency 2 cycles from accept.
- WAIT_MEM, mem_valid=0: counter++.
- Timeout: when counter reaches MEM_TIMEOUT with mem_valid still 0:
  - load_err<=1 (sticky until reset).
  - Next cycle: wb_valid=1, wb_we=0, wb_data=0.
  - Return to IDLE.
  - mem_valid in the same cycle as the timeout wins: normal writeback, no error.
- mem_valid in IDLE is ignored.
- in_valid in WAIT_MEM is not accepted; upstream holds the op.
- wb_* hold their last values when wb_valid=0, except wb_we and fwd_valid, which are 0 whenever wb_valid=0.

Optional Feature:
- Macro WB_ZERO_GUARD_EN.
- Defined: a writeback with wb_addr==0 forces wb_we=0 and fwd_valid=0; wb_valid still pulses; wb_data unchanged.
- Undefined: address 0 is written like any other register.

Test Plan:
- ALU op: src_data[0]=32'h0000_1234, src_sel=0, rd_addr=5, rd_we=1, one cycle in_valid -> next cycle wb_valid=1, wb_we=1, wb_addr=5, wb_data=32'h1234, fwd_valid=1; following cycle wb_valid=0, wb_we=0.
- Back-to-back: sel=1 (32'hAAAA_0001, rd=3), then sel=2 (32'hBBBB_0002, rd=4) on consecutive cycles -> wb pulses on consecutive cycles with matching data/addr; in_ready stays 1.
- Load: is_load=1, rd=7 accepted; mem_valid=1 with mem_data=32'hDEAD_BEEF three cycles later -> in_ready=0 during wait; one cycle later wb_data=32'hDEADBEEF, wb_addr=7; in_valid during wait is not accepted.
- Timeout with MEM_TIMEOUT=4: load accepted, mem_valid never asserted -> load_err=1 after timeout; single wb_valid pulse with wb_we=0; in_ready returns to 1; load_err stays 1 until rst_n=0.
- Reset mid-load: rst_n=0 for one cycle during WAIT_MEM, then mem_valid=1 -> no wb_valid, all outputs 0, in_ready=1.
- WB_ZERO_GUARD_EN defined: op with rd_addr=0, rd_we=1 -> wb_valid=1, wb_we=0, fwd_valid=0; same op with macro undefined -> wb_we=1.
